// File: rtl/wb_stage_pipelined.sv
// wb_stage_pipelined: MEM/WB register with load align/extend, link select, misalign detect, retire counter
module wb_stage_pipelined #(
  parameter int DATA_W        = 32,
  parameter int REG_AW        = 5,
  parameter bit ZERO_REG_GATE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [1:0]        wb_sel,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  input  logic [1:0]        byte_off,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_addr,
  output logic              wb_we,
  output logic              wb_valid,
  output logic              misalign,
  output logic [CNT_W-1:0]  retired
);
  logic [7:0]        b_lane;
  logic [15:0]       h_lane;
  logic [31:0]       lane32;
  logic              sx;
  logic              fill;
  logic              mis;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] data_q, data_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;
  logic              rw_q, rw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  always_comb begin
    sx     = ~load_unsigned;
    b_lane = mem_rdata[8*byte_off +: 8];
    h_lane = mem_rdata[16*byte_off[1] +: 16];
    lane32 = (load_size == 2'b00) ? {{24{sx & b_lane[7]}}, b_lane} :
             (load_size == 2'b01) ? {{16{sx & h_lane[15]}}, h_lane} : mem_rdata[31:0];
    // lane32 already carries byte/half extension; fill only matters above bit 31
    fill      = sx & lane32[31];
    load_data = DATA_W'(lane32) | ({DATA_W{fill}} << 32);
    mis       = ((load_size == 2'b01) & byte_off[0]) | (load_size[1] & (byte_off != 2'b00));
    sel_data  = (wb_sel == 2'b01) ? load_data : (wb_sel == 2'b10) ? pc_plus4 : alu_result;
  end
  always_comb begin
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    rw_d    = rw_q;
    cnt_d   = cnt_q;
    if (flush) begin
      data_d  = '0;
      addr_d  = '0;
      valid_d = 1'b0;
      mis_d   = 1'b0;
      rw_d    = 1'b0;
    end else if (!stall) begin
      data_d  = sel_data;
      addr_d  = write_reg;
      valid_d = in_valid;
      mis_d   = in_valid & (wb_sel == 2'b01) & mis;
      rw_d    = reg_write;
      cnt_d   = cnt_q + CNT_W'(in_valid);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
    end
  end
  assign wb_data  = data_q;
  assign wb_addr  = addr_q;
  assign wb_valid = valid_q;
  assign misalign = mis_q;
  assign retired  = cnt_q;
  assign wb_we    = valid_q & rw_q & ~mis_q & ~(ZERO_REG_GATE & (addr_q == '0));
endmodule

// File: tb/tb_wb_stage_pipelined.sv
// tb_wb_stage_pipelined: scoreboard bench for wb_stage_pipelined (CNT_W=4 to reach the wrap quickly)
module tb_wb_stage_pipelined;
  localparam int CW = 4;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [31:0] alu_result = '0, mem_rdata = '0, pc_plus4 = '0;
  logic [1:0] wb_sel = '0, load_size = '0, byte_off = '0;
  logic load_unsigned = 1'b0, reg_write = 1'b0;
  logic [4:0] write_reg = '0;
  logic [31:0] wb_data;
  logic [4:0] wb_addr;
  logic wb_we, wb_valid, misalign;
  logic [CW-1:0] retired;
  wb_stage_pipelined #(.DATA_W(32), .REG_AW(5), .ZERO_REG_GATE(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .pc_plus4(pc_plus4), .wb_sel(wb_sel),
    .load_size(load_size), .load_unsigned(load_unsigned), .byte_off(byte_off),
    .reg_write(reg_write), .write_reg(write_reg), .wb_data(wb_data), .wb_addr(wb_addr),
    .wb_we(wb_we), .wb_valid(wb_valid), .misalign(misalign), .retired(retired)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        valid;
    logic        we;
    logic        mis;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  int tests = 0, fails = 0;
  logic [CW-1:0] exp_ret = '0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic exp_t model(input logic v, input logic [1:0] sel, input logic [31:0] alu,
                                 input logic [31:0] rdata, input logic [31:0] pc, input logic [1:0] size,
                                 input logic uns, input logic [1:0] off, input logic rw, input logic [4:0] rd);
    exp_t e;
    logic [31:0] ld;
    logic m;
    case (size)
      2'b00: begin
        ld = (rdata >> (off * 8)) & 32'hFF;
        if (!uns && ld[7]) ld = ld | 32'hFFFF_FF00;
        m = 1'b0;
      end
      2'b01: begin
        ld = (off[1] ? (rdata >> 16) : rdata) & 32'hFFFF;
        if (!uns && ld[15]) ld = ld | 32'hFFFF_0000;
        m = off[0];
      end
      default: begin
        ld = rdata;
        m = (off != 2'b00);
      end
    endcase
    e.data  = (sel == 2'b01) ? ld : (sel == 2'b10) ? pc : alu;
    e.addr  = rd;
    e.valid = v;
    e.mis   = v & (sel == 2'b01) & m;
    e.we    = v & rw & ~e.mis & (rd != 5'd0);
    return e;
  endfunction
  task automatic check_state(input string tag, input exp_t e);
    chk({tag, ".data"}, 64'(wb_data), 64'(e.data));
    chk({tag, ".addr"}, 64'(wb_addr), 64'(e.addr));
    chk({tag, ".valid"}, 64'(wb_valid), 64'(e.valid));
    chk({tag, ".we"}, 64'(wb_we), 64'(e.we));
    chk({tag, ".mis"}, 64'(misalign), 64'(e.mis));
    chk({tag, ".ret"}, 64'(retired), 64'(exp_ret));
  endtask
  task automatic issue(input string tag, input logic v, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc, input logic [1:0] size,
                       input logic uns, input logic [1:0] off, input logic rw, input logic [4:0] rd);
    in_valid = v; wb_sel = sel; alu_result = alu; mem_rdata = rdata; pc_plus4 = pc;
    load_size = size; load_unsigned = uns; byte_off = off; reg_write = rw; write_reg = rd;
    sb.push_back(model(v, sel, alu, rdata, pc, size, uns, off, rw, rd));
    @(posedge clk);
    #1;
    if (v) exp_ret = exp_ret + 1'b1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      cur = sb.pop_front();
      check_state(tag, cur);
    end
  endtask
  initial begin
    exp_t z;
    z = '{data: '0, addr: '0, valid: 1'b0, we: 1'b0, mis: 1'b0};
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", z);
    @(negedge clk);
    rst_n = 1'b1;
    issue("alu", 1, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 2'b00, 0, 2'b00, 1, 5'd5);
    issue("lb_s", 1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 2'b00, 0, 2'd3, 1, 5'd6);
    issue("lbu", 1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 2'b00, 1, 2'd3, 1, 5'd6);
    issue("lb_off1", 1, 2'b01, 32'h0, 32'h80FF_7F01, 32'h0, 2'b00, 0, 2'd1, 1, 5'd7);
    issue("lh_s", 1, 2'b01, 32'h0, 32'h8001_0000, 32'h0, 2'b01, 0, 2'd2, 1, 5'd8);
    issue("lhu", 1, 2'b01, 32'h0, 32'h8001_0000, 32'h0, 2'b01, 1, 2'd2, 1, 5'd8);
    issue("lh_mis", 1, 2'b01, 32'h0, 32'h8001_0000, 32'h0, 2'b01, 0, 2'd1, 1, 5'd9);
    issue("lw_mis", 1, 2'b01, 32'h0, 32'hDEAD_BEEF, 32'h0, 2'b10, 0, 2'd2, 1, 5'd9);
    issue("lw", 1, 2'b01, 32'h0, 32'hDEAD_BEEF, 32'h0, 2'b11, 0, 2'd0, 1, 5'd10);
    issue("alu_misoff", 1, 2'b00, 32'hCAFE_0001, 32'h0, 32'h0, 2'b10, 0, 2'd3, 1, 5'd11);
    issue("sel11", 1, 2'b11, 32'h1357_9BDF, 32'h0, 32'h5555, 2'b01, 0, 2'd1, 1, 5'd12);
    issue("link", 1, 2'b10, 32'h0, 32'h0, 32'h0040_0008, 2'b00, 0, 2'd0, 1, 5'd31);
    issue("link_r0", 1, 2'b10, 32'h0, 32'h0, 32'h0040_0008, 2'b00, 0, 2'd0, 1, 5'd0);
    issue("no_rw", 1, 2'b00, 32'h77, 32'h0, 32'h0, 2'b00, 0, 2'd0, 0, 5'd3);
    issue("bubble", 0, 2'b01, 32'h0, 32'hFFFF_FFFF, 32'h0, 2'b01, 0, 2'd1, 1, 5'd4);
    issue("pre_stall", 1, 2'b00, 32'hA5A5_0F0F, 32'h0, 32'h0, 2'b00, 0, 2'd0, 1, 5'd13);
    stall = 1'b1;
    in_valid = 1'b1; alu_result = 32'h1111_2222; write_reg = 5'd20;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_state($sformatf("stall%0d", i), cur);
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    cur = z;
    check_state("stall_flush", cur);
    flush = 1'b0; stall = 1'b0;
    issue("post_flush", 1, 2'b01, 32'h0, 32'h0000_8000, 32'h0, 2'b01, 0, 2'd0, 1, 5'd14);
    stall = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_ret = '0;
    check_state("async_rst", z);
    @(negedge clk);
    stall = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++)
      issue($sformatf("cnt%0d", i), 1, 2'b00, $urandom, 32'h0, 32'h0, 2'b00, 0, 2'd0, 1, 5'(i + 1));
    issue("wrap", 1, 2'b00, 32'h0BAD_F00D, 32'h0, 32'h0, 2'b00, 0, 2'd0, 1, 5'd2);
    chk("wrap_zero", 64'(retired), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
